// File: rtl/bus_timer.sv
// bus_timer: memory-mapped prescaled interval timer on a shared 8-bit tristate bus,
// with a single-line raise/ack interrupt handshake to the processor.
module bus_timer #(
  parameter logic [7:0]  BASE_ADDR  = 8'hF0,
  parameter int unsigned PRESCALE   = 100000,
  parameter logic [7:0]  PERIOD_RST = 8'd100
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic {
    IRQ_IDLE   = 1'b0,
    IRQ_RAISED = 1'b1
  } irq_state_t;

  logic [1:0]    ctrl_r;
  logic [7:0]    period_r;
  logic [7:0]    count_r;
  logic [PW-1:0] presc_r;
  logic          pending_r;
  irq_state_t    state_r;
  logic          rd_en_r;
  logic [7:0]    rd_data_r;

  logic [7:0]    offset_s;
  logic          hit_s;
  logic          wr_ctrl_s;
  logic          wr_period_s;
  logic          wr_count_s;
  logic          wr_status_s;
  logic          tick_s;
  logic [7:0]    last_s;
  logic          event_s;
  logic          set_pend_s;
  logic          irq_clr_s;
  logic [7:0]    rd_mux_s;

  // Address decode, tick/interval-event detection and read-data selection.
  always_comb begin
    offset_s    = BUS_ADDR - BASE_ADDR;
    hit_s       = (offset_s[7:2] == 6'd0);
    wr_ctrl_s   = hit_s && BUS_WE && (offset_s[1:0] == 2'd0);
    wr_period_s = hit_s && BUS_WE && (offset_s[1:0] == 2'd1);
    wr_count_s  = hit_s && BUS_WE && (offset_s[1:0] == 2'd2);
    wr_status_s = hit_s && BUS_WE && (offset_s[1:0] == 2'd3);
    tick_s      = ctrl_r[0] && (presc_r == PRESC_MAX);
    // PERIOD=0 wraps to 255 here, giving a 256-tick interval
    last_s      = period_r - 8'd1;
    event_s     = tick_s && !wr_count_s && (count_r == last_s);
    set_pend_s  = event_s && ctrl_r[1];
    irq_clr_s   = wr_status_s || ((state_r == IRQ_RAISED) && BUS_INTERRUPT_ACK);
    case (offset_s[1:0])
      2'd0:    rd_mux_s = {6'd0, ctrl_r};
      2'd1:    rd_mux_s = period_r;
      2'd2:    rd_mux_s = count_r;
      2'd3:    rd_mux_s = {7'd0, pending_r};
      default: rd_mux_s = 8'd0;
    endcase
  end

  // Control registers, prescaler and tick counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrl_r   <= 2'd0;
      period_r <= PERIOD_RST;
      count_r  <= 8'd0;
      presc_r  <= {PW{1'b0}};
    end else begin
      if (wr_ctrl_s) begin
        ctrl_r <= BUS_DATA[1:0];
      end
      if (wr_period_s) begin
        period_r <= BUS_DATA;
      end
      if (wr_count_s) begin
        count_r <= 8'd0;
        presc_r <= {PW{1'b0}};
      end else if (tick_s) begin
        presc_r <= {PW{1'b0}};
        count_r <= event_s ? 8'd0 : count_r + 8'd1;
      end else if (ctrl_r[0]) begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Pending flag and interrupt handshake FSM; a fresh event outranks a clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pending_r <= 1'b0;
      state_r   <= IRQ_IDLE;
    end else begin
      if (set_pend_s) begin
        pending_r <= 1'b1;
      end else if (irq_clr_s) begin
        pending_r <= 1'b0;
      end
      case (state_r)
        IRQ_IDLE: begin
          if (pending_r && !wr_status_s) begin
            state_r <= IRQ_RAISED;
          end
        end
        IRQ_RAISED: begin
          if (irq_clr_s && !set_pend_s) begin
            state_r <= IRQ_IDLE;
          end
        end
        default: state_r <= IRQ_IDLE;
      endcase
    end
  end

  // Read path: latch addressed value, drive the bus for the following cycle only.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_en_r   <= 1'b0;
      rd_data_r <= 8'd0;
    end else begin
      rd_en_r   <= hit_s && !BUS_WE;
      rd_data_r <= rd_mux_s;
    end
  end

  assign BUS_DATA            = rd_en_r ? rd_data_r : 8'hzz;
  assign BUS_INTERRUPT_RAISE = (state_r == IRQ_RAISED);

endmodule

// File: tb/tb_bus_timer.sv
// Randomised self-checking bench for bus_timer against a behavioural timer model.
module tb_bus_timer;

  localparam int PRESCALE = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  wire  [7:0] bus_data;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic       raise;
  logic       ack;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  logic       released;
  logic [7:0] last_bus;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_ctrl, m_period, m_count, m_presc, m_pend, m_raised, m_rd_en, m_rd_data;

  bus_timer #(.BASE_ADDR(8'hF0), .PRESCALE(PRESCALE), .PERIOD_RST(8'd100)) dut (
    .CLK(clk), .RESET(reset_n), .BUS_DATA(bus_data), .BUS_ADDR(bus_addr),
    .BUS_WE(bus_we), .BUS_INTERRUPT_RAISE(raise), .BUS_INTERRUPT_ACK(ack)
  );

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;
  assign released = (bus_data === 8'hzz);

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_period = 100; m_count = 0; m_presc = 0;
    m_pend = 0; m_raised = 0; m_rd_en = 0; m_rd_data = 0;
  endtask

  function automatic bit event_next();
    int last;
    last = (m_period == 0) ? 255 : m_period - 1;
    return ((m_ctrl & 1) != 0) && (m_presc == PRESCALE - 1) && (m_count == last);
  endfunction

  task automatic model_step(input bit we, input bit [7:0] addr, input bit [7:0] data, input bit a);
    int off, rv, last, n_cnt, n_presc, n_pend, n_raised;
    bit hit, en, ie, wr_cnt, wr_st, tick, ev;
    off    = (int'(addr) - 'hF0 + 256) % 256;
    hit    = (off < 4);
    en     = (m_ctrl & 1) != 0;
    ie     = (m_ctrl & 2) != 0;
    case (off)
      0: rv = m_ctrl;
      1: rv = m_period;
      2: rv = m_count;
      3: rv = m_pend;
      default: rv = 0;
    endcase
    wr_cnt = hit && we && (off == 2);
    wr_st  = hit && we && (off == 3);
    tick   = en && (m_presc == PRESCALE - 1);
    last   = (m_period == 0) ? 255 : m_period - 1;
    ev     = tick && !wr_cnt && (m_count == last);
    n_cnt   = wr_cnt ? 0 : (tick ? (ev ? 0 : (m_count + 1) % 256) : m_count);
    n_presc = wr_cnt ? 0 : (en ? (m_presc + 1) % PRESCALE : m_presc);
    n_pend  = (ev && ie) ? 1 : ((wr_st || (m_raised != 0 && a)) ? 0 : m_pend);
    if (m_raised != 0) n_raised = ((a || wr_st) && !(ev && ie)) ? 0 : 1;
    else               n_raised = (m_pend != 0 && !wr_st) ? 1 : 0;
    m_rd_en = (hit && !we) ? 1 : 0;
    if (hit && !we) m_rd_data = rv;
    if (hit && we && off == 0) m_ctrl = data & 3;
    if (hit && we && off == 1) m_period = data;
    m_count = n_cnt; m_presc = n_presc; m_pend = n_pend; m_raised = n_raised;
  endtask

  // One bus cycle, entered and left at the falling edge.
  task automatic cyc_raw(input logic we, input logic [7:0] addr, input logic [7:0] data, input logic a);
    bus_we = we; bus_addr = addr; tb_wdata = data; tb_drv = we; ack = a;
    @(posedge clk);
    #1;
    tb_drv = 1'b0;
    model_step(we, addr, data, a);
    #1;
    check_value("irq", raise, m_raised);
    if (m_rd_en != 0) check_value("rdata", {released, bus_data}, {1'b0, 8'(m_rd_data)});
    else              check_value("release", released, 1'b1);
    last_bus = bus_data;
    @(negedge clk);
  endtask

  task automatic cyc(input logic we, input logic [7:0] addr, input logic [7:0] data, input logic a);
    if (we && m_rd_en != 0) cyc_raw(1'b0, 8'h00, 8'h00, 1'b0);
    cyc_raw(we, addr, data, a);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    cyc(1'b1, addr, data, 1'b0);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [7:0] v);
    cyc(1'b0, addr, 8'h00, 1'b0);
    v = last_bus;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic wait_raise(input int max, output int n);
    n = 0;
    while (!raise && n < max) begin
      cyc(1'b0, 8'h00, 8'h00, 1'b0);
      n++;
    end
  endtask

  initial begin
    logic [7:0] v;
    int n;
    int seen;
    reset_n = 1'b0; bus_we = 1'b0; bus_addr = 8'h00; ack = 1'b0;
    tb_drv = 1'b0; tb_wdata = 8'h00; last_bus = 8'h00;
    model_reset();
    #1;
    check_value("rst_irq", raise, 1'b0);
    check_value("rst_bus", released, 1'b1);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Reset values
    rd(8'hF0, v); check_value("rst_ctrl", v, 8'h00);
    rd(8'hF1, v); check_value("rst_period", v, 8'd100);
    rd(8'hF2, v); check_value("rst_count", v, 8'h00);
    rd(8'hF3, v); check_value("rst_status", v, 8'h00);

    // Period 3 with interrupts: raise 3 ticks after enable plus the FSM cycle
    wr(8'hF1, 8'd3);
    wr(8'hF0, 8'h03);
    wait_raise(40, n);
    check_value("raise_lat", n, 13);
    rd(8'hF2, v); check_value("cnt_at_irq", v, 8'h00);
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    check_value("ack_drop", raise, 1'b0);

    // IE=0: events dropped, COUNT cycles 0..2
    wr(8'hF0, 8'h01);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      idle(1);
      if (raise) seen = 1;
    end
    check_value("ie0_noirq", seen, 0);
    for (int i = 0; i < 6; i++) begin
      rd(8'hF2, v);
      check_value("ie0_cnt", v < 8'd3, 1'b1);
      idle($urandom_range(0, 3));
    end

    // Ack coincident with a new event: event wins
    wr(8'hF0, 8'h03);
    wait_raise(20, n);
    check_value("raise2", raise, 1'b1);
    n = 0;
    while (!event_next() && n < 20) begin idle(1); n++; end
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    check_value("ack_vs_event", raise, 1'b1);
    idle(1);
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    check_value("ack_after", raise, 1'b0);

    // PERIOD=0 -> 256-tick interval, COUNT write restarts it
    wr(8'hF1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 8'h00, 1'b1);
    idle(300);
    check_value("p256_quiet", raise, 1'b0);
    wr(8'hF2, 8'h5A);
    rd(8'hF2, v); check_value("cnt_clr", v, 8'h00);
    wait_raise(1100, n);
    check_value("p256_lat", n, 1024);
    cyc(1'b1, 8'hF3, 8'h00, 1'b0);
    check_value("status_clr", raise, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] a, d;
      logic w, k;
      a = ($urandom_range(0, 7) < 6) ? 8'(8'hF0 + $urandom_range(0, 3)) : 8'($urandom);
      w = ($urandom_range(0, 2) == 0);
      d = (a == 8'hF1) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      if (a == 8'hF0 && $urandom_range(0, 1) == 1) d = 8'h03;
      k = ($urandom_range(0, 5) == 0);
      cyc(w, a, d, k);
    end

    // Async reset in the middle of a read with RAISE high
    wr(8'hF1, 8'd2);
    wr(8'hF0, 8'h03);
    wait_raise(40, n);
    check_value("raise3", raise, 1'b1);
    cyc(1'b0, 8'hF1, 8'h00, 1'b0);
    check_value("drv_before_rst", released, 1'b0);
    reset_n = 1'b0;
    #1;
    check_value("rst_mid_bus", released, 1'b1);
    check_value("rst_mid_irq", raise, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rd(8'hF0, v); check_value("rst2_ctrl", v, 8'h00);
    rd(8'hF1, v); check_value("rst2_period", v, 8'd100);
    rd(8'hF2, v); check_value("rst2_count", v, 8'h00);
    rd(8'hF3, v); check_value("rst2_status", v, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
